// File: rtl/pc_fetch_sync.sv
// Clocked fetch stage closing the loop with the asynchronous four-phase PC.
// Optional `PC_FETCH_TIMEOUT_EN adds a watchdog with a sticky fetch_err flag.
module pc_fetch_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IMM_MASK    = 8'h80,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pc_data,
    input  logic       pc_req,
    output logic       pc_ack,
    output logic [1:0] pc_inc,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_rdata,
    input  logic       mem_rvalid,
    output logic [7:0] instr,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic       busy,
    output logic       fetch_err
);

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        OUT,
        ACK_HI,
        ACK_LO
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [7:0]             addr_q, addr_d;
    logic [7:0]             instr_q, instr_d;
    logic [1:0]             inc_q, inc_d;
    logic                   ack_q, rd_q, vld_q;
    logic                   tmo;

    assign req_s = sync_q[SYNC_STAGES-1];

`ifdef PC_FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;
    logic          waiting;

    assign waiting = (state_q == MEM_WAIT) || (state_q == ACK_HI);
    assign tmo     = waiting && (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Counter restarts whenever the FSM enters a waiting state.
    always_comb begin
        cnt_d = '0;
        if (waiting && (state_d == state_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | tmo;
        end
    end

    assign fetch_err = err_q;
`else
    assign tmo       = 1'b0;
    assign fetch_err = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        inc_d   = inc_q;
        unique case (state_q)
            IDLE: begin
                if (req_s) begin
                    addr_d  = pc_data;
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: state_d = MEM_WAIT;
            MEM_WAIT: begin
                if (mem_rvalid) begin
                    instr_d = mem_rdata;
                    inc_d   = |(mem_rdata & IMM_MASK) ? 2'b10 : 2'b01;
                    state_d = OUT;
                end else if (tmo) begin
                    inc_d   = 2'b00;
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (instr_ready) state_d = ACK_HI;
            end
            ACK_HI: begin
                if (!req_s) begin
                    state_d = ACK_LO;
                end else if (tmo) begin
                    inc_d   = 2'b00;
                    state_d = IDLE;
                end
            end
            ACK_LO:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered so pc_ack reaches the async side glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            inc_q   <= 2'b00;
            ack_q   <= 1'b0;
            rd_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pc_req};
            addr_q  <= addr_d;
            instr_q <= instr_d;
            inc_q   <= inc_d;
            ack_q   <= (state_d == ACK_HI);
            rd_q    <= (state_d == MEM_REQ);
            vld_q   <= (state_d == OUT);
        end
    end

    assign pc_ack      = ack_q;
    assign pc_inc      = inc_q;
    assign mem_addr    = addr_q;
    assign mem_rd      = rd_q;
    assign instr       = instr_q;
    assign instr_valid = vld_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pc_fetch_sync.sv
// Directed self-checking bench for pc_fetch_sync (SYNC_STAGES=2).
// Build with +define+PC_FETCH_TIMEOUT_EN to also exercise the watchdog.
module tb_pc_fetch_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc_data;
    logic       pc_req;
    logic       pc_ack;
    logic [1:0] pc_inc;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       mem_rvalid;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       busy;
    logic       fetch_err;

    int ncmp  = 0;
    int nfail = 0;

    pc_fetch_sync #(
        .SYNC_STAGES(2),
        .IMM_MASK   (8'h80),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_data    (pc_data),
        .pc_req     (pc_req),
        .pc_ack     (pc_ack),
        .pc_inc     (pc_inc),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise pc_req and run to the OUT state (instr_valid high).
    task automatic do_fetch(input logic [7:0] a, input logic [7:0] d,
                            input logic [1:0] inc, input logic rdy);
        pc_data     = a;
        pc_req      = 1'b1;
        instr_ready = rdy;
        tick();
        tick();
        chk("idle_until_sync", busy, 1'b0);
        tick();
        chk("mem_rd_hi", mem_rd, 1'b1);
        chk("mem_addr", mem_addr, a);
        tick();
        chk("mem_rd_one_cycle", mem_rd, 1'b0);
        chk("no_valid_in_wait", instr_valid, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        chk("instr_valid_lat", instr_valid, 1'b1);
        chk("instr", instr, d);
        chk("pc_inc_pre_ack", pc_inc, inc);
        chk("ack_low_in_out", pc_ack, 1'b0);
    endtask

    task automatic ack_rise(input logic [1:0] inc);
        instr_ready = 1'b1;
        tick();
        chk("ack_rise", pc_ack, 1'b1);
        chk("valid_cleared", instr_valid, 1'b0);
        chk("pc_inc_at_ack", pc_inc, inc);
    endtask

    task automatic release_req(input logic [1:0] inc);
        pc_req = 1'b0;
        tick();
        chk("ack_hold1", pc_ack, 1'b1);
        tick();
        chk("ack_hold2", pc_ack, 1'b1);
        tick();
        chk("ack_fall", pc_ack, 1'b0);
        chk("pc_inc_at_fall", pc_inc, inc);
        tick();
        chk("back_idle", busy, 1'b0);
        chk("pc_inc_idle", pc_inc, inc);
    endtask

    initial begin
        rst         = 1'b1;
        pc_data     = 8'h00;
        pc_req      = 1'b0;
        mem_rdata   = 8'h00;
        mem_rvalid  = 1'b0;
        instr_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_ack", pc_ack, 1'b0);
        chk("rst_inc", pc_inc, 2'b00);
        chk("rst_rd", mem_rd, 1'b0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_instr", instr, 8'h00);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", fetch_err, 1'b0);

        // Basic fetch, short opcode
        do_fetch(8'h56, 8'h12, 2'b01, 1'b1);
        ack_rise(2'b01);
        release_req(2'b01);

        // Two-byte opcode
        do_fetch(8'h60, 8'hA3, 2'b10, 1'b1);
        ack_rise(2'b10);
        release_req(2'b10);

        // Downstream stall
        do_fetch(8'h61, 8'h12, 2'b01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_instr", instr, 8'h12);
            chk("stall_ack", pc_ack, 1'b0);
        end
        ack_rise(2'b01);
        release_req(2'b01);

        // Stray response while idle
        mem_rvalid = 1'b1;
        mem_rdata  = 8'hFF;
        tick();
        tick();
        mem_rvalid = 1'b0;
        chk("stray_busy", busy, 1'b0);
        chk("stray_valid", instr_valid, 1'b0);
        chk("stray_instr", instr, 8'h12);
        chk("stray_rd", mem_rd, 1'b0);

        // Reset while waiting on memory
        pc_data = 8'h70;
        pc_req  = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("wait_busy", busy, 1'b1);
        pc_req = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_ack", pc_ack, 1'b0);
        chk("mrst_inc", pc_inc, 2'b00);
        chk("mrst_rd", mem_rd, 1'b0);
        chk("mrst_addr", mem_addr, 8'h00);
        chk("mrst_instr", instr, 8'h00);
        chk("mrst_valid", instr_valid, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_err", fetch_err, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 8'h99;
        tick();
        mem_rvalid = 1'b0;
        chk("late_busy", busy, 1'b0);
        chk("late_instr", instr, 8'h00);
        do_fetch(8'h71, 8'h05, 2'b01, 1'b1);
        ack_rise(2'b01);
        release_req(2'b01);

        // Request held high after acknowledge
        do_fetch(8'h56, 8'h12, 2'b01, 1'b1);
        ack_rise(2'b01);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_ack", pc_ack, 1'b1);
            chk("held_rd", mem_rd, 1'b0);
            chk("held_addr", mem_addr, 8'h56);
        end
        release_req(2'b01);
        do_fetch(8'h57, 8'h84, 2'b10, 1'b1);
        ack_rise(2'b10);
        release_req(2'b10);
        chk("err_default", fetch_err, 1'b0);

`ifdef PC_FETCH_TIMEOUT_EN
        // Memory never answers
        pc_data = 8'h20;
        pc_req  = 1'b1;
        tick();
        tick();
        tick();
        chk("tmo_rd", mem_rd, 1'b1);
        pc_req = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_still_wait", busy, 1'b1);
        chk("tmo_err_pre", fetch_err, 1'b0);
        tick();
        chk("tmo_err", fetch_err, 1'b1);
        chk("tmo_idle", busy, 1'b0);
        chk("tmo_ack", pc_ack, 1'b0);
        chk("tmo_inc", pc_inc, 2'b00);
        tick();
        tick();
        chk("tmo_stays_idle", busy, 1'b0);
        do_fetch(8'h33, 8'h40, 2'b01, 1'b1);
        ack_rise(2'b01);
        release_req(2'b01);
        chk("tmo_sticky", fetch_err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("tmo_rst_clear", fetch_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
